int_controller: RTL and testbench

- Multi-source interrupt controller for the RAT MCU.
- Latches interrupt requests from N peripheral sources, applies a per-source enable mask and picks the highest-priority pending source.
- Drives the single INTR line into the MCU and runs the acknowledge/return handshake with the CPU control unit.
- Supplies the serviced source index on VECTOR so the ISR can dispatch.

---
 rtl/int_controller.sv | 103 ++++++++++
 tb/tb_int_controller.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// Multi-source interrupt controller for the RAT MCU: it latches requests, masks them, picks a fixed-priority winner and runs the ACK/DONE handshake.
// Define INTC_EDGE_DETECT_EN for rising-edge request capture; the default build captures requests by level.
module int_controller #(
    parameter int          N        = 8,
    parameter int          IW       = $clog2(N),
    parameter logic [N-1:0] MASK_RST = {N{1'b1}}
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [N-1:0]  IRQ,
    input  logic          MASK_WE,
    input  logic [N-1:0]  MASK_IN,
    input  logic          INT_ACK,
    input  logic          INT_DONE,
    output logic          INTR,
    output logic [IW-1:0] VECTOR,
    output logic [N-1:0]  PENDING,
    output logic          BUSY
);

    typedef enum logic [1:0] {IDLE, REQ, SERVICE} state_t;

    state_t          state, state_nx;
    logic [N-1:0]    mask;
    logic [N-1:0]    eligible;
    logic [N-1:0]    events;
    logic [N-1:0]    ack_clr;
    logic [IW-1:0]   winner;
    logic [IW-1:0]   vector_nx;

`ifdef INTC_EDGE_DETECT_EN
    logic [N-1:0] irq_q;

    // History starts all-ones so a line already high at reset release is not an event.
    always_ff @(posedge CLK) begin
        if (RST) irq_q <= '1;
        else     irq_q <= IRQ;
    end

    assign events = IRQ & ~irq_q;
`else
    assign events = IRQ;
`endif

    assign eligible = PENDING & mask;

    // The scan runs from the highest index down, so the lowest set bit is the last one written.
    always_comb begin
        winner = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (eligible[N-1-k]) winner = IW'(N - 1 - k);
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (|eligible) state_nx = REQ;
            REQ: begin
                if (INT_ACK)         state_nx = SERVICE;
                else if (~|eligible) state_nx = IDLE;
            end
            SERVICE: if (INT_DONE) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        vector_nx = VECTOR;
        ack_clr   = '0;
        case (state)
            IDLE: if (|eligible) vector_nx = winner;
            REQ: begin
                if (INT_ACK)        ack_clr   = {{(N-1){1'b0}}, 1'b1} << VECTOR;
                else if (|eligible) vector_nx = winner;
            end
            default: ;
        endcase
    end

    // A new event in the same cycle overrides the acknowledge clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            INTR    <= 1'b0;
            BUSY    <= 1'b0;
            VECTOR  <= '0;
            PENDING <= '0;
            mask    <= MASK_RST;
        end else begin
            INTR    <= (state_nx == REQ);
            BUSY    <= (state_nx == SERVICE);
            VECTOR  <= vector_nx;
            PENDING <= (PENDING & ~ack_clr) | events;
            if (MASK_WE) mask <= MASK_IN;
        end
    end

endmodule

// File: tb/tb_int_controller.sv
// Scoreboard bench for int_controller: a behavioural model queues the expected outputs and a monitor compares them after every edge.
module tb_int_controller;

    localparam int N  = 8;
    localparam int IW = 3;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic [N-1:0]  IRQ = '0;
    logic          MASK_WE = 1'b0;
    logic [N-1:0]  MASK_IN = '0;
    logic          INT_ACK = 1'b0;
    logic          INT_DONE = 1'b0;
    logic          INTR;
    logic [IW-1:0] VECTOR;
    logic [N-1:0]  PENDING;
    logic          BUSY;

    int_controller #(.N(N), .IW(IW), .MASK_RST(8'hFF)) dut (
        .CLK(CLK), .RST(RST), .IRQ(IRQ), .MASK_WE(MASK_WE), .MASK_IN(MASK_IN),
        .INT_ACK(INT_ACK), .INT_DONE(INT_DONE), .INTR(INTR), .VECTOR(VECTOR),
        .PENDING(PENDING), .BUSY(BUSY)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          intr;
        bit [IW-1:0] vec;
        bit [N-1:0]  pend;
        bit          busy;
        int          cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   cycle = 0;

    // Reference model: the controller is idle, waiting for an ACK, or in service.
    typedef enum {P_IDLE, P_WAIT, P_SERVE} phase_t;
    phase_t      m_phase = P_IDLE;
    bit [N-1:0]  m_pend  = '0;
    bit [N-1:0]  m_mask  = '1;
    bit [N-1:0]  m_prev  = '1;
    bit [IW-1:0] m_vec   = '0;

    task automatic model(bit r, bit [N-1:0] irq, bit mwe, bit [N-1:0] min, bit ack, bit done);
        bit [N-1:0]  elig;
        bit [N-1:0]  np;
        int          best;
        bit          edge_mode;
`ifdef INTC_EDGE_DETECT_EN
        edge_mode = 1'b1;
`else
        edge_mode = 1'b0;
`endif
        if (r) begin
            m_phase = P_IDLE; m_pend = '0; m_mask = '1; m_prev = '1; m_vec = '0;
            return;
        end
        elig = m_pend & m_mask;
        best = -1;
        for (int k = N - 1; k >= 0; k--) if (elig[k]) best = k;
        np = m_pend;
        case (m_phase)
            P_IDLE:  if (best >= 0) begin m_phase = P_WAIT; m_vec = IW'(best); end
            P_WAIT:  if (ack) begin np[m_vec] = 1'b0; m_phase = P_SERVE; end
                     else if (best < 0) m_phase = P_IDLE;
                     else m_vec = IW'(best);
            P_SERVE: if (done) m_phase = P_IDLE;
            default: ;
        endcase
        for (int k = 0; k < N; k++)
            if (irq[k] && (!edge_mode || !m_prev[k])) np[k] = 1'b1;
        m_pend = np;
        if (mwe) m_mask = min;
        m_prev = irq;
    endtask

    task automatic drive(bit r, bit [N-1:0] irq, bit mwe, bit [N-1:0] min, bit ack, bit done);
        exp_t e;
        @(negedge CLK);
        RST = r; IRQ = irq; MASK_WE = mwe; MASK_IN = min; INT_ACK = ack; INT_DONE = done;
        model(r, irq, mwe, min, ack, done);
        cycle++;
        e.intr = (m_phase == P_WAIT);
        e.vec  = m_vec;
        e.pend = m_pend;
        e.busy = (m_phase == P_SERVE);
        e.cyc  = cycle;
        exp_q.push_back(e);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic pulse(bit [N-1:0] irq);
        drive(1'b0, irq, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic ack();
        drive(1'b0, '0, 1'b0, '0, 1'b1, 1'b0);
    endtask

    task automatic done();
        drive(1'b0, '0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    task automatic wmask(bit [N-1:0] m);
        drive(1'b0, '0, 1'b1, m, 1'b0, 1'b0);
    endtask

    // Monitor: the DUT presents a fresh registered output after every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                tests++;
                if (INTR !== e.intr) begin
                    fails++; $display("FAIL intr cyc=%0d got=%b exp=%b", e.cyc, INTR, e.intr);
                end
                tests++;
                if (VECTOR !== e.vec) begin
                    fails++; $display("FAIL vector cyc=%0d got=%0d exp=%0d", e.cyc, VECTOR, e.vec);
                end
                tests++;
                if (PENDING !== e.pend) begin
                    fails++; $display("FAIL pending cyc=%0d got=%h exp=%h", e.cyc, PENDING, e.pend);
                end
                tests++;
                if (BUSY !== e.busy) begin
                    fails++; $display("FAIL busy cyc=%0d got=%b exp=%b", e.cyc, BUSY, e.busy);
                end
            end
        end
    end

    initial begin
        bit [N-1:0] irq, min;
        bit         mwe, r;

        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        idle(1);

        // single event on source 3
        pulse(8'h08); idle(2); ack(); idle(1); done(); idle(2);

        // pre-emption of 5 by 1, then 5 is serviced afterwards
        pulse(8'h20); idle(2); pulse(8'h02); idle(1); ack(); idle(1); done(); idle(3);
        ack(); idle(1); done(); idle(2);

        // masking, unmasking and clearing the mask while requesting
        wmask(8'hFE); pulse(8'h01); idle(2); wmask(8'hFF); idle(2);
        wmask(8'h00); idle(2); wmask(8'hFF); idle(2); ack(); done(); idle(2);

        // new event on the acknowledged source in the ACK cycle
        pulse(8'h04); idle(2);
        drive(1'b0, 8'h04, 1'b0, '0, 1'b1, 1'b0);
        idle(1); done(); idle(2); ack(); idle(1); done(); idle(2);

        // reset while servicing, with 6 and 7 pending and the mask altered
        wmask(8'h3F); pulse(8'h01); idle(2);
        drive(1'b0, 8'hC0, 1'b0, '0, 1'b1, 1'b0);
        idle(1);
        drive(1'b1, '0, 1'b0, '0, 1'b0, 1'b0);
        done(); idle(2); pulse(8'h80); idle(2); ack(); done(); idle(2);

        // IRQ[4] held high across an ACK/DONE sequence
        for (int i = 0; i < 10; i++)
            drive(1'b0, 8'h10, 1'b0, '0, (i == 3), (i == 5));
        idle(3); ack(); idle(1); done(); idle(3);

        // randomized traffic
        for (int c = 0; c < 800; c++) begin
            irq = '0;
            for (int k = 0; k < N; k++) irq[k] = ($urandom_range(0, 9) == 0);
            mwe = ($urandom_range(0, 24) == 0);
            min = ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom);
            r   = ($urandom_range(0, 149) == 0);
            drive(r, irq, mwe, min, ($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0));
        end
        idle(2);

        @(posedge CLK);
        #3;
        if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL drain got=%0d exp=0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
